ans_enc_ctrl: RTL and testbench

ANS_ENC_CTRL -- requirements
Module: ans_enc_ctrl

---
 rtl/ans_enc_ctrl_pkg.sv | 24 ++
 rtl/ans_enc_ctrl_if.sv | 46 ++++
 rtl/ans_byte_fifo.sv | 65 ++++++
 rtl/ans_enc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ans_enc_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ans_enc_ctrl_pkg.sv
// ans_enc_ctrl_pkg
//   Widths and the controller state encoding. The rANS encoder datapath
//   uses the same package so that operand widths agree on both sides.
package ans_enc_ctrl_pkg;

    localparam int SYM_WIDTH   = 8;
    localparam int CNT_WIDTH   = 8;
    localparam int STATE_WIDTH = 16;
    localparam int CUM_WIDTH   = SYM_WIDTH + CNT_WIDTH;

    localparam int FIFO_DEPTH  = 4;
    localparam int WAIT_MIN    = 2;

    typedef enum logic [2:0] {
        S_CFG   = 3'd0,
        S_BUILD = 3'd1,
        S_RUN   = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/ans_enc_ctrl_if.sv
// ans_enc_ctrl_if
//   Stream signals around the ANS encoder controller.
//   master : controller side (ans_enc_ctrl)
//   slave  : surrounding logic (symbol source, encoder core, byte sink)
//   Groups: symbol stream (sym/sym_vld/sym_rdy), encoder operands
//   (enc_s_count/enc_s_cumulative/enc_total_count/enc_in_vld/enc_in_rdy),
//   encoder bytes (enc_out/enc_out_vld/enc_out_rdy), downstream bytes
//   (byte_out/byte_vld/byte_rdy).
interface ans_enc_ctrl_if
    import ans_enc_ctrl_pkg::*;
#(
    parameter int NSYM = 16
);
    localparam int IW = $clog2(NSYM);

    logic [IW-1:0]          sym;
    logic                   sym_vld;
    logic                   sym_rdy;

    logic [CNT_WIDTH-1:0]   enc_s_count;
    logic [CUM_WIDTH-1:0]   enc_s_cumulative;
    logic [STATE_WIDTH-1:0] enc_total_count;
    logic                   enc_in_vld;
    logic                   enc_in_rdy;

    logic [SYM_WIDTH-1:0]   enc_out;
    logic                   enc_out_vld;
    logic                   enc_out_rdy;

    logic [SYM_WIDTH-1:0]   byte_out;
    logic                   byte_vld;
    logic                   byte_rdy;

    modport master (
        input  sym, sym_vld, enc_in_rdy, enc_out, enc_out_vld, byte_rdy,
        output sym_rdy, enc_s_count, enc_s_cumulative, enc_total_count,
               enc_in_vld, enc_out_rdy, byte_out, byte_vld
    );

    modport slave (
        output sym, sym_vld, enc_in_rdy, enc_out, enc_out_vld, byte_rdy,
        input  sym_rdy, enc_s_count, enc_s_cumulative, enc_total_count,
               enc_in_vld, enc_out_rdy, byte_out, byte_vld
    );

endinterface

// File: rtl/ans_byte_fifo.sv
// ans_byte_fifo
//   Small byte FIFO between the encoder core and the downstream sink.
//   clk, rst_n : clock, async active-low reset
//   ena        : freezes pointers, count and storage when low
//   push, din  : write request/data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head entry, forced to 0 while empty
//   full, empty: occupancy flags
module ans_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Full gates push before any same-cycle pop is considered.
    assign do_push = ena && push && !full;
    assign do_pop  = ena && pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ans_enc_ctrl.sv
// ans_enc_ctrl
//   Sequencer for an rANS encoder core: holds the symbol frequency table,
//   builds cumulative counts, feeds one symbol's operands at a time to the
//   encoder and buffers the encoder's output bytes.
//   clk, rst_n        : clock, async active-low reset
//   ena               : global enable, everything freezes while low
//   cfg_we/addr/cnt   : frequency table write (CFG only)
//   cfg_commit        : build table (from CFG or DONE)
//   flush             : end of message
//   bus               : symbol, encoder operand, encoder byte, output byte streams
//   busy, done, err   : status (err is sticky until reset)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   CFG   | accepting table writes, waiting for commit
//   BUILD | one cum[] entry per cycle, total computed on the last entry
//   RUN   | ready for a symbol or flush
//   ISSUE | operands valid to the encoder until accepted
//   WAIT  | encoder settling, at least WAIT_MIN cycles with enc_in_vld low
//   DRAIN | flushing remaining bytes and waiting for the encoder to go idle
//   DONE  | message complete, commit rebuilds with the existing table
module ans_enc_ctrl
    import ans_enc_ctrl_pkg::*;
#(
    parameter int NSYM = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        cfg_we,
    input  logic [$clog2(NSYM)-1:0]     cfg_addr,
    input  logic [CNT_WIDTH-1:0]        cfg_cnt,
    input  logic                        cfg_commit,
    input  logic                        flush,
    ans_enc_ctrl_if.master              bus,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int IW = $clog2(NSYM);

    ctrl_state_t          state;
    ctrl_state_t          state_nxt;

    logic [CNT_WIDTH-1:0] cnt_tbl [NSYM];
    logic [CUM_WIDTH-1:0] cum_tbl [NSYM];

    logic [IW-1:0]          bidx;
    logic [CUM_WIDTH-1:0]   acc;
    logic [CUM_WIDTH-1:0]   acc_nxt;
    logic [STATE_WIDTH-1:0] total;
    logic [CNT_WIDTH-1:0]   op_cnt;
    logic [CUM_WIDTH-1:0]   op_cum;
    logic [1:0]             wait_tmr;

    logic build_last;
    logic sym_hs;
    logic sym_zero;
    logic enc_free;
    logic fifo_full;
    logic fifo_empty;

    assign acc_nxt    = acc + CUM_WIDTH'(cnt_tbl[bidx]);
    assign build_last = (bidx == IW'(NSYM - 1));
    assign sym_hs     = bus.sym_vld && bus.sym_rdy;
    assign sym_zero   = (cnt_tbl[bus.sym] == '0);
    assign enc_free   = bus.enc_in_rdy && !bus.enc_out_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_CFG;
        else if (ena) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_CFG:   if (cfg_commit) state_nxt = S_BUILD;
            S_BUILD: if (build_last) state_nxt = (acc_nxt == '0) ? S_CFG : S_RUN;
            S_RUN: begin
                // A symbol handshake (even a dropped one) masks flush.
                if (sym_hs) begin
                    if (!sym_zero) state_nxt = S_ISSUE;
                end else if (flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_ISSUE: if (bus.enc_in_rdy) state_nxt = S_WAIT;
            S_WAIT:  if (wait_tmr == '0 && enc_free) state_nxt = S_RUN;
            S_DRAIN: if (fifo_empty && enc_free) state_nxt = S_DONE;
            S_DONE:  if (cfg_commit) state_nxt = S_BUILD;
            default: state_nxt = S_CFG;
        endcase
    end

    // Handshake strobes are gated by ena so no transfer can complete while
    // the controller is frozen; status outputs simply hold.
    always_comb begin
        busy            = (state == S_BUILD) || (state == S_ISSUE) ||
                          (state == S_WAIT)  || (state == S_DRAIN);
        done            = (state == S_DONE);
        bus.sym_rdy     = ena && (state == S_RUN);
        bus.enc_in_vld  = ena && (state == S_ISSUE);
        bus.enc_out_rdy = ena && !fifo_full && (state != S_CFG);
    end

    assign bus.enc_s_count      = op_cnt;
    assign bus.enc_s_cumulative = op_cum;
    assign bus.enc_total_count  = total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSYM; i++) begin
                cnt_tbl[i] <= '0;
                cum_tbl[i] <= '0;
            end
        end else if (ena) begin
            if (state == S_CFG && cfg_we) cnt_tbl[cfg_addr] <= cfg_cnt;
            if (state == S_BUILD) cum_tbl[bidx] <= acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bidx     <= '0;
            acc      <= '0;
            total    <= '0;
            op_cnt   <= '0;
            op_cum   <= '0;
            wait_tmr <= '0;
            err      <= 1'b0;
        end else if (ena) begin
            if ((state == S_CFG || state == S_DONE) && cfg_commit) begin
                bidx <= '0;
                acc  <= '0;
            end
            if (state == S_BUILD) begin
                bidx <= bidx + IW'(1);
                acc  <= acc_nxt;
                if (build_last) begin
                    total <= STATE_WIDTH'(acc_nxt);
                    if (acc_nxt == '0) err <= 1'b1;
                end
            end
            if (sym_hs) begin
                if (sym_zero) begin
                    err <= 1'b1;
                end else begin
                    op_cnt <= cnt_tbl[bus.sym];
                    op_cum <= cum_tbl[bus.sym];
                end
            end
            // Down-counter: WAIT may only exit once it reaches zero.
            if (state == S_ISSUE && bus.enc_in_rdy)
                wait_tmr <= 2'(WAIT_MIN - 1);
            else if (state == S_WAIT && wait_tmr != '0)
                wait_tmr <= wait_tmr - 2'd1;
        end
    end

    ans_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SYM_WIDTH)
    ) u_byte_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .push  (bus.enc_out_vld && bus.enc_out_rdy),
        .din   (bus.enc_out),
        .pop   (bus.byte_vld && bus.byte_rdy),
        .dout  (bus.byte_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.byte_vld = ena && !fifo_empty;

endmodule

// File: tb/tb_ans_enc_ctrl.sv
// tb_ans_enc_ctrl
//   Self-checking bench for ans_enc_ctrl. Inputs are driven and outputs
//   sampled on the falling edge; a behavioural model (table array, byte
//   queue, sticky error flag) supplies every expected value.
module tb_ans_enc_ctrl;
    import ans_enc_ctrl_pkg::*;

    localparam int NSYM = 16;
    localparam int IW   = $clog2(NSYM);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ena;
    logic                 cfg_we;
    logic [IW-1:0]        cfg_addr;
    logic [CNT_WIDTH-1:0] cfg_cnt;
    logic                 cfg_commit;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic                 err;

    ans_enc_ctrl_if #(.NSYM(NSYM)) bus();

    ans_enc_ctrl #(.NSYM(NSYM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_cnt    (cfg_cnt),
        .cfg_commit (cfg_commit),
        .flush      (flush),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ref_cnt [NSYM];
    logic [7:0] byte_q [$];
    logic       err_exp;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int ref_cum(input int s);
        int sum = 0;
        for (int i = 0; i < s; i++) sum += ref_cnt[i];
        return sum;
    endfunction

    function automatic int ref_total();
        return ref_cum(NSYM);
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_sym_rdy"},     32'(bus.sym_rdy), 0);
        check_val({pfx, "_enc_in_vld"},  32'(bus.enc_in_vld), 0);
        check_val({pfx, "_enc_out_rdy"}, 32'(bus.enc_out_rdy), 0);
        check_val({pfx, "_byte_vld"},    32'(bus.byte_vld), 0);
        check_val({pfx, "_byte_out"},    32'(bus.byte_out), 0);
        check_val({pfx, "_busy"},        32'(busy), 0);
        check_val({pfx, "_done"},        32'(done), 0);
        check_val({pfx, "_err"},         32'(err), 0);
        check_val({pfx, "_s_count"},     32'(bus.enc_s_count), 0);
        check_val({pfx, "_s_cum"},       32'(bus.enc_s_cumulative), 0);
        check_val({pfx, "_total"},       32'(bus.enc_total_count), 0);
    endtask

    task automatic idle_inputs();
        ena             = 1'b1;
        cfg_we          = 1'b0;
        cfg_addr        = '0;
        cfg_cnt         = '0;
        cfg_commit      = 1'b0;
        flush           = 1'b0;
        bus.sym         = '0;
        bus.sym_vld     = 1'b0;
        bus.enc_in_rdy  = 1'b0;
        bus.enc_out     = '0;
        bus.enc_out_vld = 1'b0;
        bus.byte_rdy    = 1'b0;
    endtask

    // Asserts reset now, checks outputs while it is held, releases at a negedge.
    task automatic do_reset(input string pfx);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(pfx);
        byte_q.delete();
        err_exp = 1'b0;
        for (int i = 0; i < NSYM; i++) ref_cnt[i] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_table(input int vals [NSYM]);
        for (int i = 0; i < NSYM; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = IW'(i);
            cfg_cnt  = CNT_WIDTH'(vals[i]);
            ref_cnt[i] = vals[i];
            @(negedge clk);
        end
        cfg_we = 1'b0;
    endtask

    // Commit and count cycles with busy high; optional 3-cycle ena freeze.
    task automatic commit_build(input bit freeze, input string tag);
        int n = 0;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!busy) break;
            n++;
            ena = !(freeze && k >= 3 && k < 6);
            @(negedge clk);
        end
        ena = 1'b1;
        check_val({tag, "_busy_cycles"}, 32'(n), 32'(NSYM + (freeze ? 3 : 0)));
    endtask

    // One cycle of the byte path against the queue model.
    task automatic fifo_step(input bit vld, input logic [7:0] data, input bit rdy);
        bit push_ok;
        bit pop_ok;
        check_val("fifo_enc_out_rdy", 32'(bus.enc_out_rdy), 32'(byte_q.size() < FIFO_DEPTH));
        check_val("fifo_byte_vld",    32'(bus.byte_vld),    32'(byte_q.size() > 0));
        if (byte_q.size() > 0) check_val("fifo_byte_out", 32'(bus.byte_out), 32'(byte_q[0]));
        bus.enc_out_vld = vld;
        bus.enc_out     = data;
        bus.byte_rdy    = rdy;
        push_ok = vld && (byte_q.size() < FIFO_DEPTH);
        pop_ok  = rdy && (byte_q.size() > 0);
        if (pop_ok)  void'(byte_q.pop_front());
        if (push_ok) byte_q.push_back(data);
        @(negedge clk);
        bus.enc_out_vld = 1'b0;
        bus.byte_rdy    = 1'b0;
    endtask

    task automatic send_sym(input int s, input bit with_flush, input int hold);
        int exp_cnt;
        int exp_cum;
        int gap;
        check_val("sym_rdy_pre", 32'(bus.sym_rdy), 1);
        bus.sym        = IW'(s);
        bus.sym_vld    = 1'b1;
        flush          = with_flush;
        bus.enc_in_rdy = 1'b0;
        @(negedge clk);
        bus.sym_vld = 1'b0;
        flush       = 1'b0;
        if (ref_cnt[s] == 0) begin
            err_exp = 1'b1;
            check_val("zero_err",        32'(err), 1);
            check_val("zero_enc_in_vld", 32'(bus.enc_in_vld), 0);
            check_val("zero_sym_rdy",    32'(bus.sym_rdy), 1);
            check_val("zero_busy",       32'(busy), 0);
            return;
        end
        exp_cnt = ref_cnt[s];
        exp_cum = ref_cum(s);
        for (int h = 0; h <= hold; h++) begin
            check_val("issue_vld",   32'(bus.enc_in_vld), 1);
            check_val("issue_cnt",   32'(bus.enc_s_count), 32'(exp_cnt));
            check_val("issue_cum",   32'(bus.enc_s_cumulative), 32'(exp_cum));
            check_val("issue_busy",  32'(busy), 1);
            if (h == hold) bus.enc_in_rdy = 1'b1;
            @(negedge clk);
        end
        gap = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.sym_rdy) break;
            check_val("wait_vld_low", 32'(bus.enc_in_vld), 0);
            check_val("wait_cnt_hold", 32'(bus.enc_s_count), 32'(exp_cnt));
            check_val("wait_cum_hold", 32'(bus.enc_s_cumulative), 32'(exp_cum));
            gap++;
            @(negedge clk);
        end
        check_val("wait_gap_min2", 32'(gap >= WAIT_MIN), 1);
        check_val("wait_timeout",  32'(gap < 20), 1);
        check_val("after_err",     32'(err), 32'(err_exp));
        bus.enc_in_rdy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dir_tbl [NSYM];
        int rnd_tbl [NSYM];
        int a;
        idle_inputs();
        do_reset("rst0");
        check_val("post_rst_sym_rdy", 32'(bus.sym_rdy), 0);

        // Directed table {4,2,1,1,0...}
        for (int i = 0; i < NSYM; i++) dir_tbl[i] = 0;
        dir_tbl[0] = 4; dir_tbl[1] = 2; dir_tbl[2] = 1; dir_tbl[3] = 1;
        write_table(dir_tbl);
        commit_build(1'b0, "build");
        check_val("build_total",   32'(bus.enc_total_count), 32'(ref_total()));
        check_val("build_run_rdy", 32'(bus.sym_rdy), 1);
        check_val("build_err",     32'(err), 0);

        send_sym(1, 1'b0, 3);
        send_sym(3, 1'b0, 0);
        send_sym(5, 1'b0, 0);
        // flush together with a symbol: the symbol is issued, no drain
        send_sym(0, 1'b1, 1);
        check_val("flush_sym_done", 32'(done), 0);

        // Backpressure: five bytes offered with byte_rdy low
        for (int i = 0; i < 5; i++) fifo_step(1'b1, 8'(8'h10 + i), 1'b0);
        fifo_step(1'b1, 8'h14, 1'b1);
        fifo_step(1'b1, 8'h14, 1'b1);
        for (int i = 0; i < 6; i++) fifo_step(1'b0, 8'h00, 1'b1);
        check_val("bp_empty", 32'(byte_q.size()), 0);

        for (int i = 0; i < 150; i++)
            fifo_step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 10 && byte_q.size() > 0; i++) fifo_step(1'b0, 8'h00, 1'b1);

        // Flush with two bytes queued
        fifo_step(1'b1, 8'hA1, 1'b0);
        fifo_step(1'b1, 8'hA2, 1'b0);
        flush          = 1'b1;
        bus.enc_in_rdy = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("drain_busy",    32'(busy), 1);
        check_val("drain_sym_rdy", 32'(bus.sym_rdy), 0);
        repeat (2) begin
            @(negedge clk);
            check_val("drain_hold_busy", 32'(busy), 1);
            check_val("drain_hold_done", 32'(done), 0);
        end
        for (int i = 0; i < 10 && byte_q.size() > 0; i++) fifo_step(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (done) break;
            @(negedge clk);
        end
        check_val("done_flag",     32'(done), 1);
        check_val("done_busy",     32'(busy), 0);
        check_val("done_byte_vld", 32'(bus.byte_vld), 0);

        // Rebuild from DONE with a frozen stretch
        commit_build(1'b1, "rebuild");
        check_val("rebuild_total", 32'(bus.enc_total_count), 32'(ref_total()));
        check_val("rebuild_rdy",   32'(bus.sym_rdy), 1);
        check_val("rebuild_err",   32'(err), 32'(err_exp));
        send_sym(2, 1'b0, 0);

        // Reset in the middle of WAIT with a byte queued
        fifo_step(1'b1, 8'h5C, 1'b0);
        bus.sym        = IW'(2);
        bus.sym_vld    = 1'b1;
        bus.enc_in_rdy = 1'b1;
        @(negedge clk);
        bus.sym_vld = 1'b0;
        check_val("mw_issue_vld", 32'(bus.enc_in_vld), 1);
        @(negedge clk);
        check_val("mw_wait_vld",  32'(bus.enc_in_vld), 0);
        check_val("mw_wait_busy", 32'(busy), 1);
        do_reset("rst_mid");
        repeat (3) begin
            check_val("post_mw_enc_in_vld", 32'(bus.enc_in_vld), 0);
            check_val("post_mw_byte_vld",   32'(bus.byte_vld), 0);
            check_val("post_mw_sym_rdy",    32'(bus.sym_rdy), 0);
            @(negedge clk);
        end
        bus.enc_in_rdy = 1'b0;

        // Table reset to zero: commit must flag err and return to CFG
        commit_build(1'b0, "zero_total");
        check_val("zero_total_err",  32'(err), 1);
        check_val("zero_total_cfg",  32'(bus.sym_rdy), 0);
        check_val("zero_total_busy", 32'(busy), 0);

        // Random table and random symbols
        do_reset("rst_rnd");
        for (int i = 0; i < NSYM; i++)
            rnd_tbl[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        if (rnd_tbl[0] == 0) rnd_tbl[0] = 1;
        write_table(rnd_tbl);
        commit_build(1'b0, "rnd_build");
        check_val("rnd_total", 32'(bus.enc_total_count), 32'(ref_total()));
        a = int'($urandom_range(0, NSYM - 1));
        cfg_we   = 1'b1;
        cfg_addr = IW'(a);
        cfg_cnt  = CNT_WIDTH'(ref_cnt[a] ^ 8'h5A);
        @(negedge clk);
        cfg_we = 1'b0;
        send_sym(a, 1'b0, 0);
        for (int i = 0; i < 40; i++)
            send_sym(int'($urandom_range(0, NSYM - 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)));
        check_val("rnd_total_hold", 32'(bus.enc_total_count), 32'(ref_total()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
